register_file: RTL and testbench

Architectural register file with rename tags. It sits between the decoder, the reorder buffer and the issue queues. For each decoded instruction it supplies source operands: either a value, or the ROB tag of the in-flight producer. It records the destination rename at issue and writes retired results from the ROB commit port. A flush discards all speculative renames and keeps the committed values.

---
 rtl/register_file.sv | 114 +++++++++++
 tb/tb_register_file.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural register file with ROB rename tags: supplies each source operand as
// a value or as its in-flight producer tag, records renames and retires ROB commits.
module register_file #(
   parameter int ROB_WIDTH = 4,
   parameter int REG_WIDTH = 5
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 flush,
   input  logic [REG_WIDTH-1:0] dec_rs1,
   input  logic [REG_WIDTH-1:0] dec_rs2,
   input  logic                 dec_rdy,
   input  logic [REG_WIDTH-1:0] dec_rd,
   input  logic [ROB_WIDTH-1:0] dec_rob_id,
   output logic                 dec_ready_j,
   output logic                 dec_ready_k,
   output logic [31:0]          dec_val_j,
   output logic [31:0]          dec_val_k,
   output logic [ROB_WIDTH-1:0] dec_tag_j,
   output logic [ROB_WIDTH-1:0] dec_tag_k,
   output logic [ROB_WIDTH-1:0] rob_query_j,
   output logic [ROB_WIDTH-1:0] rob_query_k,
   input  logic                 rob_ready_j,
   input  logic                 rob_ready_k,
   input  logic [31:0]          rob_data_j,
   input  logic [31:0]          rob_data_k,
   input  logic [REG_WIDTH-1:0] commit_reg_id,
   input  logic [31:0]          commit_data,
   input  logic [ROB_WIDTH-1:0] commit_rob_id
);

   localparam int NUM_REGS = 2 ** REG_WIDTH;

   typedef struct packed {
      logic                 ready;
      logic [31:0]          value;
      logic [ROB_WIDTH-1:0] tag;
      logic [ROB_WIDTH-1:0] query;
   } operand_t;

   logic [31:0]          val  [NUM_REGS];
   logic [ROB_WIDTH-1:0] tag  [NUM_REGS];
   logic [NUM_REGS-1:0]  busy;

   operand_t op_j, op_k;

   // Priority: committed value, then same-cycle commit bypass, then ROB search result.
   function automatic operand_t lookup(input logic [REG_WIDTH-1:0] r,
                                       input logic                 rob_ready,
                                       input logic [31:0]          rob_data);
      operand_t o;
      o.ready = 1'b1;
      o.value = val[r];
      o.tag   = '0;
      o.query = '0;
      if (busy[r]) begin
         o.query = tag[r];
         if (commit_reg_id == r && commit_reg_id != '0 && commit_rob_id == tag[r]) begin
            o.value = commit_data;
         end else if (rob_ready) begin
            o.value = rob_data;
         end else begin
            o.ready = 1'b0;
            o.value = '0;
            o.tag   = tag[r];
         end
      end
      return o;
   endfunction

   always_comb begin
      op_j = lookup(dec_rs1, rob_ready_j, rob_data_j);
      op_k = lookup(dec_rs2, rob_ready_k, rob_data_k);
   end

   assign dec_ready_j = op_j.ready;
   assign dec_val_j   = op_j.value;
   assign dec_tag_j   = op_j.tag;
   assign rob_query_j = op_j.query;
   assign dec_ready_k = op_k.ready;
   assign dec_val_k   = op_k.value;
   assign dec_tag_k   = op_k.tag;
   assign rob_query_k = op_k.query;

   // NOTE: all state uses non-blocking assignments so every lookup this cycle sees pre-edge state.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            val[i] <= '0;
            tag[i] <= '0;
         end
         busy <= '0;
      end else if (rdy_in) begin
         if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) tag[i] <= '0;
            busy <= '0;
         end else begin
            if (commit_reg_id != '0) begin
               val[commit_reg_id] <= commit_data;
               if (busy[commit_reg_id] && tag[commit_reg_id] == commit_rob_id &&
                   !(dec_rdy && dec_rd == commit_reg_id))
                  busy[commit_reg_id] <= 1'b0;
            end
            // A rename outranks the busy-clear of a same-cycle commit to the same register.
            if (dec_rdy && dec_rd != '0) begin
               busy[dec_rd] <= 1'b1;
               tag[dec_rd]  <= dec_rob_id;
            end
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: rename, lookup, commit bypass,
// flush, stall and x0 behaviour against hand-computed values.
module tb_register_file;

   localparam int RW = 4;

   logic          clk_in = 1'b0;
   logic          rst_in, rdy_in, flush, dec_rdy;
   logic [4:0]    dec_rs1, dec_rs2, dec_rd, commit_reg_id;
   logic [RW-1:0] dec_rob_id, commit_rob_id;
   logic          dec_ready_j, dec_ready_k, rob_ready_j, rob_ready_k;
   logic [31:0]   dec_val_j, dec_val_k, rob_data_j, rob_data_k, commit_data;
   logic [RW-1:0] dec_tag_j, dec_tag_k, rob_query_j, rob_query_k;

   int errors = 0;
   int checks = 0;

   register_file #(.ROB_WIDTH(RW), .REG_WIDTH(5)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rdy(dec_rdy), .dec_rd(dec_rd),
      .dec_rob_id(dec_rob_id),
      .dec_ready_j(dec_ready_j), .dec_ready_k(dec_ready_k),
      .dec_val_j(dec_val_j), .dec_val_k(dec_val_k),
      .dec_tag_j(dec_tag_j), .dec_tag_k(dec_tag_k),
      .rob_query_j(rob_query_j), .rob_query_k(rob_query_k),
      .rob_ready_j(rob_ready_j), .rob_ready_k(rob_ready_k),
      .rob_data_j(rob_data_j), .rob_data_k(rob_data_k),
      .commit_reg_id(commit_reg_id), .commit_data(commit_data),
      .commit_rob_id(commit_rob_id)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", name, observed, expected);
      end
   endtask

   // Advance past the next rising edge and return inputs to idle.
   task automatic tick();
      @(posedge clk_in);
      #1;
      flush = 0; dec_rdy = 0; dec_rd = 0; dec_rob_id = 0;
      commit_reg_id = 0; commit_data = 0; commit_rob_id = 0;
      rob_ready_j = 0; rob_ready_k = 0; rob_data_j = 0; rob_data_k = 0;
   endtask

   task automatic rename(input logic [4:0] rd, input logic [RW-1:0] id);
      dec_rdy = 1; dec_rd = rd; dec_rob_id = id;
   endtask

   task automatic commit(input logic [4:0] rd, input logic [31:0] data, input logic [RW-1:0] id);
      commit_reg_id = rd; commit_data = data; commit_rob_id = id;
   endtask

   initial begin
      rst_in = 1; rdy_in = 1; dec_rs1 = 0; dec_rs2 = 0;
      tick();
      tick();
      rst_in = 0;

      // Reset state
      dec_rs1 = 3; dec_rs2 = 0; #1;
      check("rst_ready_j", dec_ready_j, 1);
      check("rst_val_j",   dec_val_j,   0);
      check("rst_tag_j",   dec_tag_j,   0);
      check("rst_query_j", rob_query_j, 0);
      check("rst_ready_k", dec_ready_k, 1);
      check("rst_val_k",   dec_val_k,   0);

      // Rename x5 -> tag 2; lookup waits on the ROB, then forwards its data
      rename(5, 2);
      tick();
      dec_rs1 = 5; #1;
      check("ren_ready_j", dec_ready_j, 0);
      check("ren_tag_j",   dec_tag_j,   2);
      check("ren_query_j", rob_query_j, 2);
      check("ren_val_j",   dec_val_j,   0);
      rob_ready_j = 1; rob_data_j = 32'h55; #1;
      check("rob_ready_j", dec_ready_j, 1);
      check("rob_val_j",   dec_val_j,   32'h55);
      check("rob_tag_j",   dec_tag_j,   0);

      // Re-rename x5 -> tag 3; commit of old tag 2 keeps busy
      rename(5, 3);
      tick();
      commit(5, 32'h11, 2); #1;
      check("stale_bypass_ready", dec_ready_j, 0);
      tick();
      #1;
      check("stale_ready_j", dec_ready_j, 0);
      check("stale_tag_j",   dec_tag_j,   3);
      commit(5, 32'h22, 3); #1;
      check("byp_ready_j", dec_ready_j, 1);
      check("byp_val_j",   dec_val_j,   32'h22);
      tick();
      #1;
      check("commit_ready_j", dec_ready_j, 1);
      check("commit_val_j",   dec_val_j,   32'h22);

      // Same-cycle commit to owner and rename of x7: rename wins busy, bypass feeds lookup
      rename(7, 4);
      tick();
      dec_rs2 = 7;
      commit(7, 32'h99, 4);
      rename(7, 6); #1;
      check("same_byp_ready_k", dec_ready_k, 1);
      check("same_byp_val_k",   dec_val_k,   32'h99);
      tick();
      #1;
      check("same_ready_k", dec_ready_k, 0);
      check("same_tag_k",   dec_tag_k,   6);
      check("same_query_k", rob_query_k, 6);

      // Flush discards renames and the same-cycle commit/rename
      rename(1, 1); tick();
      rename(2, 2); tick();
      rename(3, 3); tick();
      dec_rs1 = 1; #1;
      check("pre_flush_ready_x1", dec_ready_j, 0);
      flush = 1;
      commit(1, 32'hAB, 1);
      rename(4, 5);
      tick();
      dec_rs1 = 1; dec_rs2 = 4; #1;
      check("fl_ready_x1", dec_ready_j, 1);
      check("fl_val_x1",   dec_val_j,   0);
      check("fl_ready_x4", dec_ready_k, 1);
      check("fl_query_x4", rob_query_k, 0);
      dec_rs1 = 2; dec_rs2 = 3; #1;
      check("fl_ready_x2", dec_ready_j, 1);
      check("fl_ready_x3", dec_ready_k, 1);
      dec_rs1 = 5; dec_rs2 = 7; #1;
      check("fl_val_x5", dec_val_j, 32'h22);
      check("fl_val_x7", dec_val_k, 32'h99);

      // Commit to a non-busy register writes val
      commit(9, 32'h3C, 0);
      tick();
      dec_rs1 = 9; #1;
      check("free_commit_val", dec_val_j, 32'h3C);

      // rdy_in low: no state change
      rdy_in = 0;
      commit(2, 32'h77, 0);
      rename(2, 7);
      tick();
      rdy_in = 1;
      dec_rs1 = 2; #1;
      check("stall_ready_x2", dec_ready_j, 1);
      check("stall_val_x2",   dec_val_j,   0);

      // x0 ignores rename and commit
      rename(0, 9);
      commit(0, 32'h1234, 9);
      tick();
      dec_rs1 = 0; #1;
      check("x0_ready", dec_ready_j, 1);
      check("x0_val",   dec_val_j,   0);
      check("x0_query", rob_query_j, 0);

      // Reset overrides rename/commit and ignores rdy_in
      rename(6, 8);
      tick();
      rst_in = 1; rdy_in = 0;
      rename(6, 9);
      commit(5, 32'hFF, 0);
      tick();
      rst_in = 0; rdy_in = 1;
      dec_rs1 = 5; dec_rs2 = 6; #1;
      check("rst2_val_x5",   dec_val_j,   0);
      check("rst2_ready_x6", dec_ready_k, 1);
      check("rst2_tag_x6",   dec_tag_k,   0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
